// File: rtl/lcd_pkg.sv
// Shared constants and types for the 160x80 monochrome LCD bus (pump and sniffer).
// Latency: n/a (package).
// Backpressure: n/a (package).
package lcd_pkg;

    localparam int LCD_COLS    = 160;
    localparam int LCD_ROWS    = 80;
    localparam int LCD_PIXELS  = LCD_COLS * LCD_ROWS;
    localparam int LCD_ADDR_W  = 14;
    localparam int LCD_COL_W   = 8;
    localparam int LCD_LINE_W  = 7;
    localparam int LCD_WDOG_W  = 12;
    localparam int LCD_TIMEOUT = 4095;

    // Frames are written top address first, counting down, so the pump can
    // replay a captured frame without reordering.
    localparam logic [LCD_ADDR_W-1:0] LCD_LAST_ADDR = LCD_ADDR_W'(LCD_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAPT = 2'd1,
        FULL = 2'd2
    } lcd_state_t;

    // Next write address: count down, wrapping from 0 back to the top.
    function automatic logic [LCD_ADDR_W-1:0] lcd_addr_dec(input logic [LCD_ADDR_W-1:0] a);
        return (a == '0) ? LCD_LAST_ADDR : a - 1'b1;
    endfunction

endpackage

// File: rtl/spld_sniff_if.sv
// LCD panel bus bundle (CP pixel clock, DO data, LP line pulse, FP frame pulse, FM polarity).
// Latency: none, plain wires.
// Backpressure: none, the panel bus is free-running; master drives, slave only observes.
interface spld_sniff_if;

    logic CP;
    logic DO;
    logic LP;
    logic FP;
    logic FM;

    modport master (output CP, output DO, output LP, output FP, output FM);
    modport slave  (input  CP, input  DO, input  LP, input  FP, input  FM);

endinterface

// File: rtl/lcd_sync_edge.sv
// Two-flop synchronizer for one asynchronous pin plus rise/fall pulses of the synced value.
// Latency: q follows d after 2 clk; rise/fall are combinational off q and its delayed copy.
// Backpressure: none.
// Ports: clk, rstn (async active-low), d (async pin), q (synced), rise/fall (1-cycle pulses).
module lcd_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic s1;
    logic q_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1  <= 1'b0;
            q   <= 1'b0;
            q_d <= 1'b0;
        end else begin
            s1  <= d;
            q   <= s1;
            q_d <= q;
        end
    end

    assign rise = q & ~q_d;
    assign fall = ~q & q_d;

endmodule

// File: rtl/spld_sniff.sv
// Captures frames from an external 160x80 LCD bus and writes one pixel per CP fall into frame RAM.
// Latency: CP pin fall to wr_en_o strobe is 3 clk (2 sync + 1 register); fm_o follows FM by 2 clk.
// Backpressure: none, the RAM write port must accept every strobe; bus is sampled blindly.
// Ports: clk, rstn (async active-low); bus (slave modport: CP/DO/LP/FP/FM pins);
//        wr_addr_o/wr_data_o/wr_en_o (frame RAM write port); frame_done_o (1-cycle pulse);
//        fm_o (synced FM); line_err_o, lost_o (sticky until reset).
module spld_sniff
    import lcd_pkg::*;
(
    input  logic                  clk,
    input  logic                  rstn,
    spld_sniff_if.slave           bus,
    output logic [LCD_ADDR_W-1:0] wr_addr_o,
    output logic                  wr_data_o,
    output logic                  wr_en_o,
    output logic                  frame_done_o,
    output logic                  fm_o,
    output logic                  line_err_o,
    output logic                  lost_o
);

    localparam logic [LCD_COL_W-1:0]  COLS_C    = LCD_COL_W'(LCD_COLS);
    localparam logic [LCD_LINE_W-1:0] ROWS_C    = LCD_LINE_W'(LCD_ROWS);
    localparam logic [LCD_WDOG_W-1:0] TIMEOUT_C = LCD_WDOG_W'(LCD_TIMEOUT);

    // ---------------------------------------------------------------- sync
    logic cp_q, cp_rise, cp_fall;
    logic lp_q, lp_rise, lp_fall;
    logic fp_q, fp_rise, fp_fall;

    lcd_sync_edge u_cp (.clk(clk), .rstn(rstn), .d(bus.CP), .q(cp_q), .rise(cp_rise), .fall(cp_fall));
    lcd_sync_edge u_lp (.clk(clk), .rstn(rstn), .d(bus.LP), .q(lp_q), .rise(lp_rise), .fall(lp_fall));
    lcd_sync_edge u_fp (.clk(clk), .rstn(rstn), .d(bus.FP), .q(fp_q), .rise(fp_rise), .fall(fp_fall));

    // DO goes through the same two stages as CP, so do_ff[1] is the value
    // that was on the pin when the CP fall now being seen happened.
    logic [1:0] do_ff;
    logic [1:0] fm_ff;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            do_ff <= 2'b00;
            fm_ff <= 2'b00;
        end else begin
            do_ff <= {do_ff[0], bus.DO};
            fm_ff <= {fm_ff[0], bus.FM};
        end
    end

    assign fm_o = fm_ff[1];

    logic unused_sync;
    assign unused_sync = ^{cp_q, cp_rise, lp_q, lp_rise, fp_q, fp_fall};

    // ---------------------------------------------------------------- capture FSM
    lcd_state_t            state_q;
    logic [LCD_ADDR_W-1:0] addr_q;
    logic [LCD_COL_W-1:0]  col_q;
    logic [LCD_LINE_W-1:0] line_q;
    logic [LCD_WDOG_W-1:0] wdog_q;

    // The pixel of this cycle is accounted before any line end in the same
    // cycle, so col_px is the column count the line end must judge.
    logic                  take_px;
    logic [LCD_COL_W-1:0]  col_px;
    logic [LCD_LINE_W-1:0] line_nxt;

    always_comb begin
        take_px  = (state_q == CAPT) && cp_fall;
        col_px   = take_px ? col_q + 1'b1 : col_q;
        line_nxt = line_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            addr_q       <= LCD_LAST_ADDR;
            col_q        <= '0;
            line_q       <= '0;
            wdog_q       <= '0;
            wr_addr_o    <= LCD_LAST_ADDR;
            wr_data_o    <= 1'b0;
            wr_en_o      <= 1'b0;
            frame_done_o <= 1'b0;
            line_err_o   <= 1'b0;
            lost_o       <= 1'b0;
        end else begin
            wr_en_o      <= 1'b0;
            frame_done_o <= 1'b0;

            case (state_q)
                IDLE: begin
                    wdog_q <= '0;
                    if (fp_rise) begin
                        state_q   <= CAPT;
                        addr_q    <= LCD_LAST_ADDR;
                        wr_addr_o <= LCD_LAST_ADDR;
                        col_q     <= '0;
                        line_q    <= '0;
                    end
                end

                default: begin // CAPT or FULL
                    if (fp_rise) begin
                        // Frame resync; a same-cycle LP fall or pixel is dropped.
                        state_q   <= CAPT;
                        addr_q    <= LCD_LAST_ADDR;
                        wr_addr_o <= LCD_LAST_ADDR;
                        col_q     <= '0;
                        line_q    <= '0;
                        wdog_q    <= '0;
                        if (line_q != '0) begin
                            line_err_o <= 1'b1;
                        end
                    end else if (!cp_fall && wdog_q == TIMEOUT_C) begin
                        // Bus went quiet mid-frame: abandon it.
                        lost_o  <= 1'b1;
                        state_q <= IDLE;
                        wdog_q  <= '0;
                    end else begin
                        wdog_q <= cp_fall ? '0 : wdog_q + 1'b1;

                        if (take_px) begin
                            wr_en_o   <= 1'b1;
                            wr_data_o <= do_ff[1];
                            wr_addr_o <= addr_q;
                            addr_q    <= lcd_addr_dec(addr_q);
                        end

                        // Extra pixel on an already full line.
                        if (cp_fall && state_q == FULL) begin
                            line_err_o <= 1'b1;
                        end

                        if (lp_fall) begin
                            if (col_px != COLS_C) begin
                                line_err_o <= 1'b1;
                            end
                            col_q  <= '0;
                            line_q <= line_nxt;
                            if (line_nxt == ROWS_C) begin
                                frame_done_o <= 1'b1;
                                state_q      <= IDLE;
                            end else begin
                                state_q <= CAPT;
                            end
                        end else begin
                            col_q <= col_px;
                            if (col_px == COLS_C) begin
                                state_q <= FULL;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spld_sniff.sv
// Directed bench for spld_sniff: drives the LCD bus pin by pin and checks the write stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_spld_sniff;
    import lcd_pkg::*;

    logic clk = 1'b0;
    logic rstn;
    always #15 clk = ~clk;

    spld_sniff_if bus();

    logic [LCD_ADDR_W-1:0] wr_addr;
    logic wr_data, wr_en, frame_done, fm, line_err, lost;

    spld_sniff dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_en_o      (wr_en),
        .frame_done_o (frame_done),
        .fm_o         (fm),
        .line_err_o   (line_err),
        .lost_o       (lost)
    );

    int checks = 0;
    int fails  = 0;

    // Expected-write model driven by the stimulus
    typedef struct packed {
        logic [13:0] a;
        logic        d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         e;
    logic [13:0] m_addr = 14'd12799;
    int          m_col  = 0;
    int          m_line = 0;
    bit          m_capt = 1'b0;
    int          pcnt   = 0;

    // Write / frame_done monitor
    int          wcnt    = 0;
    int          mon_bad = 0;
    int          fd_cnt  = 0;
    logic [13:0] last_addr = '0;

    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if (wr_en === 1'b1) begin
                wcnt++;
                last_addr = wr_addr;
                if (exp_q.size() == 0) begin
                    mon_bad++;
                end else begin
                    e = exp_q.pop_front();
                    if (e.a !== wr_addr || e.d !== wr_data) mon_bad++;
                end
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic pat(input int n);
        return (((n * 7) / 3 + n / 11) % 2) == 1;
    endfunction

    task automatic model_fall(input logic d);
        if (m_capt && m_col < 160) begin
            exp_q.push_back(wr_t'{m_addr, d});
            m_addr = (m_addr == 14'd0) ? 14'd12799 : m_addr - 14'd1;
            m_col++;
        end
    endtask

    task automatic model_lp();
        if (m_capt) begin
            m_col = 0;
            m_line++;
            if (m_line == 80) m_capt = 1'b0;
        end
    endtask

    task automatic px(input logic d, input int hi, input int lo);
        bus.DO = d;
        bus.CP = 1'b1;
        ticks(hi);
        bus.CP = 1'b0;
        model_fall(d);
        ticks(lo);
    endtask

    task automatic pixels(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            px(pat(pcnt), hi, lo);
            pcnt++;
        end
    endtask

    task automatic lp_pulse();
        bus.LP = 1'b1;
        ticks(2);
        bus.LP = 1'b0;
        bus.FP = 1'b0;
        model_lp();
        ticks(2);
    endtask

    // Last pixel of a line whose CP fall lands together with the LP fall
    task automatic px_lp();
        logic d;
        d = pat(pcnt);
        pcnt++;
        bus.DO = d;
        bus.CP = 1'b1;
        bus.LP = 1'b1;
        ticks(2);
        bus.CP = 1'b0;
        bus.LP = 1'b0;
        bus.FP = 1'b0;
        model_fall(d);
        model_lp();
        ticks(2);
    endtask

    task automatic fp_rise();
        bus.FP = 1'b1;
        m_capt = 1'b1;
        m_addr = 14'd12799;
        m_col  = 0;
        m_line = 0;
        ticks(4);
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            pixels(160, 1, 1);
            lp_pulse();
        end
    endtask

    initial begin
        #6000000;
        $display("FAIL run_bound: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rstn   = 1'b0;
        bus.CP = 1'b0;
        bus.DO = 1'b0;
        bus.LP = 1'b0;
        bus.FP = 1'b0;
        bus.FM = 1'b0;
        ticks(3);

        // Reset state
        check("rst_wr_addr", wr_addr, 12799);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_line_err", line_err, 0);
        check("rst_lost", lost, 0);
        check("rst_state", dut.state_q, IDLE);
        rstn = 1'b1;
        ticks(2);

        // FM: two-clock synchronizer
        bus.FM = 1'b1;
        ticks(1);
        check("fm_after_1clk", fm, 0);
        ticks(1);
        check("fm_after_2clk", fm, 1);

        // Bus activity before any FP is ignored
        pixels(5, 1, 1);
        lp_pulse();
        ticks(5);
        check("idle_no_writes", wcnt, 0);

        // Frame A: clean frame, first pixels at pump pace, two lines end on a shared CP/LP fall
        fp_rise();
        pixels(10, 18, 18);
        pixels(150, 1, 1);
        lp_pulse();
        lines(4);
        pixels(159, 1, 1);
        px_lp();
        lines(73);
        pixels(159, 1, 1);
        px_lp();
        ticks(5);
        check("a_writes", wcnt, 12800);
        check("a_last_addr", last_addr, 0);
        check("a_frame_done", fd_cnt, 1);
        check("a_line_err", line_err, 0);
        check("a_lost", lost, 0);
        check("a_state", dut.state_q, IDLE);
        check("a_stream_bad", mon_bad, 0);
        check("a_queue_left", exp_q.size(), 0);

        // Frame B: pin-to-strobe latency, then FP rise at line 40
        fp_rise();
        bus.DO = 1'b1;
        bus.CP = 1'b1;
        ticks(2);
        bus.CP = 1'b0;
        model_fall(1'b1);
        ticks(1);
        check("lat_clk1_en", wr_en, 0);
        ticks(1);
        check("lat_clk2_en", wr_en, 0);
        ticks(1);
        check("lat_clk3_en", wr_en, 1);
        check("lat_clk3_addr", wr_addr, 12799);
        check("lat_clk3_data", wr_data, 1);
        ticks(1);
        check("lat_clk4_en", wr_en, 0);
        pixels(159, 1, 1);
        lp_pulse();
        lines(39);
        ticks(5);
        check("b_writes", wcnt, 19200);
        check("b_addr_before_fp", wr_addr, 6400);
        check("b_err_before_fp", line_err, 0);
        fp_rise();
        check("b_fp_addr_reload", wr_addr, 12799);
        check("b_fp_line_err", line_err, 1);
        check("b_fp_no_done", fd_cnt, 1);

        // Frame C: the 80 lines after the resync
        lines(80);
        ticks(5);
        check("c_writes", wcnt, 32000);
        check("c_frame_done", fd_cnt, 2);
        check("c_last_addr", last_addr, 0);
        check("c_stream_bad", mon_bad, 0);
        check("c_state", dut.state_q, IDLE);

        // Reset mid-line 10
        fp_rise();
        lines(10);
        pixels(50, 1, 1);
        ticks(5);
        check("d_writes_pre_rst", wcnt, 33650);
        rstn = 1'b0;
        m_capt = 1'b0;
        exp_q.delete();
        ticks(1);
        check("d_rst_wr_addr", wr_addr, 12799);
        check("d_rst_wr_en", wr_en, 0);
        check("d_rst_wr_data", wr_data, 0);
        check("d_rst_line_err", line_err, 0);
        check("d_rst_lost", lost, 0);
        check("d_rst_fm", fm, 0);
        check("d_rst_state", dut.state_q, IDLE);
        ticks(1);
        rstn = 1'b1;
        pixels(20, 1, 1);
        lp_pulse();
        ticks(5);
        check("d_no_writes_after_rst", wcnt, 33650);

        // Frame E: short line, long line, then watchdog
        fp_rise();
        check("e_fp_addr", wr_addr, 12799);
        pixels(159, 1, 1);
        lp_pulse();
        ticks(4);
        check("e_short_line_err", line_err, 1);
        check("e_short_state", dut.state_q, CAPT);
        pixels(1, 1, 1);
        ticks(5);
        check("e_next_line_addr", last_addr, 12640);
        pixels(159, 1, 1);
        lp_pulse();
        pixels(161, 1, 1);
        ticks(5);
        check("e_long_writes", wcnt, 34129);
        check("e_long_state", dut.state_q, FULL);
        lp_pulse();
        ticks(3);
        check("e_after_long_state", dut.state_q, CAPT);
        pixels(80, 1, 1);
        ticks(4000);
        check("e_wdog_early_lost", lost, 0);
        ticks(200);
        check("e_wdog_lost", lost, 1);
        check("e_wdog_state", dut.state_q, IDLE);
        m_capt = 1'b0;
        pixels(30, 1, 1);
        lp_pulse();
        ticks(5);
        check("e_lost_no_writes", wcnt, 34209);
        check("e_lost_no_done", fd_cnt, 2);
        fp_rise();
        pixels(5, 1, 1);
        ticks(5);
        check("e_resume_writes", wcnt, 34214);
        check("e_resume_addr", last_addr, 12795);
        check("e_stream_bad", mon_bad, 0);
        check("e_queue_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
